apb_master_ctrl: RTL and testbench

- Single-outstanding APB initiator (bus master) for the processor-side test and control paths.
- Converts a simple valid/ready command interface into compliant APB SETUP/ACCESS transfers.
- Returns read data and a completion pulse.
- Intended to drive the APB slave models and real APB peripherals in the digitizer control fabric.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_ctrl_if.sv | 40 ++++
 rtl/apb_master_timeout.sv | 32 +++
 rtl/apb_master_ctrl.sv | 142 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator.
// Latency: none, declarations only.
// Backpressure: not applicable.
package apb_pkg;

    localparam int APB_AWIDTH = 8;
    localparam int APB_DWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command-side and APB-side signal bundle for the APB initiator.
// Latency: none, wiring only.
// Backpressure: REQ_READY gates commands; PREADY stretches ACCESS.
interface apb_master_ctrl_if
    import apb_pkg::*;
#(
    parameter int AWIDTH = APB_AWIDTH,
    parameter int DWIDTH = APB_DWIDTH
);
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WRITE;
    logic [AWIDTH-1:0] REQ_ADDR;
    logic [DWIDTH-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic [DWIDTH-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;

    // The initiator: owns the APB control lines and the response side.
    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // The environment: issues commands and plays the APB slave.
    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_master_timeout.sv
// ACCESS wait-state counter; flags the edge on which the wait budget runs out.
// Latency: o_expired is combinational from the count and i_en.
// Backpressure: none; counts only while i_en (PREADY low in ACCESS).
module apb_master_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    // The count already holds TIMEOUT-1 waits when the TIMEOUT-th wait edge arrives.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    // Wait counter: cleared when ACCESS is entered, bumped per stalled ACCESS cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB initiator: one command becomes one SETUP+ACCESS transfer.
// Latency: RSP_VALID in the 3rd cycle after accept with PREADY=1; +1 cycle per wait state.
// Backpressure: REQ_READY only in IDLE; ACCESS stalls on PREADY (abort when APB_MASTER_TIMEOUT_EN).
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int AWIDTH  = APB_AWIDTH,
    parameter int DWIDTH  = APB_DWIDTH,
    parameter int TIMEOUT = 16
) (
    input logic               PCLK,
    input logic               PRESETN,
    apb_master_ctrl_if.master bus
);

    apb_state_e        r_state,       w_nxt_state;
    logic              r_req_ready,   w_nxt_req_ready;
    logic              r_psel,        w_nxt_psel;
    logic              r_penable,     w_nxt_penable;
    logic              r_pwrite,      w_nxt_pwrite;
    logic [AWIDTH-1:0] r_paddr,       w_nxt_paddr;
    logic [DWIDTH-1:0] r_pwdata,      w_nxt_pwdata;
    logic              r_rsp_valid,   w_nxt_rsp_valid;
    logic [DWIDTH-1:0] r_rsp_rdata,   w_nxt_rsp_rdata;
    logic              r_rsp_err,     w_nxt_rsp_err;
    logic              w_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_to_clr;
    logic w_to_en;

    assign w_to_clr = (r_state == SETUP);
    assign w_to_en  = (r_state == ACCESS) && !bus.PREADY;

    apb_master_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (PCLK),
        .i_rst_n   (PRESETN),
        .i_clr     (w_to_clr),
        .i_en      (w_to_en),
        .o_expired (w_expired)
    );
`else
    // Without the watchdog ACCESS waits for PREADY forever and never aborts.
    assign w_expired = 1'b0;
`endif

    // State and every bus-visible output are registered together.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_req_ready <= w_nxt_req_ready;
            r_psel      <= w_nxt_psel;
            r_penable   <= w_nxt_penable;
            r_pwrite    <= w_nxt_pwrite;
            r_paddr     <= w_nxt_paddr;
            r_pwdata    <= w_nxt_pwdata;
            r_rsp_valid <= w_nxt_rsp_valid;
            r_rsp_rdata <= w_nxt_rsp_rdata;
            r_rsp_err   <= w_nxt_rsp_err;
        end
    end

    // Next-state and next-output decode; address/data/direction hold unless a command is taken.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_psel      = r_psel;
        w_nxt_penable   = r_penable;
        w_nxt_pwrite    = r_pwrite;
        w_nxt_paddr     = r_paddr;
        w_nxt_pwdata    = r_pwdata;
        w_nxt_rsp_valid = 1'b0;
        w_nxt_rsp_rdata = r_rsp_rdata;
        w_nxt_rsp_err   = r_rsp_err;

        case (r_state)
            IDLE: begin
                if (bus.REQ_VALID && r_req_ready) begin
                    w_nxt_pwrite  = bus.REQ_WRITE;
                    w_nxt_paddr   = bus.REQ_ADDR;
                    w_nxt_pwdata  = bus.REQ_WDATA;
                    w_nxt_psel    = 1'b1;
                    w_nxt_penable = 1'b0;
                    w_nxt_state   = SETUP;
                end
            end
            SETUP: begin
                w_nxt_penable = 1'b1;
                w_nxt_state   = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over an expiring watchdog on the same edge.
                if (bus.PREADY) begin
                    w_nxt_psel      = 1'b0;
                    w_nxt_penable   = 1'b0;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_err   = 1'b0;
                    if (!r_pwrite) begin
                        w_nxt_rsp_rdata = bus.PRDATA;
                    end
                    w_nxt_state     = IDLE;
                end else if (w_expired) begin
                    w_nxt_psel      = 1'b0;
                    w_nxt_penable   = 1'b0;
                    w_nxt_rsp_valid = 1'b1;
                    w_nxt_rsp_err   = 1'b1;
                    w_nxt_state     = IDLE;
                end
            end
            default: begin
                w_nxt_psel    = 1'b0;
                w_nxt_penable = 1'b0;
                w_nxt_state   = IDLE;
            end
        endcase

        w_nxt_req_ready = (w_nxt_state == IDLE);
    end

    assign bus.REQ_READY = r_req_ready;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP_RDATA = r_rsp_rdata;
    assign bus.RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: vector table plus multi-cycle sequences and a protocol watcher.
// Latency: stimulus on falling edges, outputs sampled on the following falling edge.
// Backpressure: PREADY driven by the bench; APB_MASTER_TIMEOUT_EN selects the abort sequence.
module tb_apb_master_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    apb_master_ctrl_if #(.AWIDTH(8), .DWIDTH(8)) bus ();

    apb_master_ctrl #(
        .AWIDTH  (8),
        .DWIDTH  (8),
        .TIMEOUT (16)
    ) dut (
        .PCLK    (clk),
        .PRESETN (rstn),
        .bus     (bus)
    );

    // Slave memory model.
    logic [7:0] mem [256];
    logic       mem_clr = 1'b1;
    assign bus.PRDATA = mem[bus.PADDR];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (rstn && bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) begin
            mem[bus.PADDR] <= bus.PWDATA;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    // Protocol watcher: compares the cycle just ended against the one before it.
    logic       p_ok = 1'b0;
    logic       p_psel, p_pen, p_pwrite, p_pready, p_acc;
    logic [7:0] p_paddr, p_pwdata;
    always @(posedge clk) begin
        if (p_ok) begin
            if (bus.PENABLE && !bus.PSEL) viol++;
            if (p_psel && !p_pen && !(bus.PSEL && bus.PENABLE)) viol++;
            if (p_psel && p_pen && !p_pready) begin
`ifdef APB_MASTER_TIMEOUT_EN
                if (bus.PSEL && ({bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA} !=
                                 {1'b1, p_paddr, p_pwrite, p_pwdata})) viol++;
`else
                if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA} !=
                    {2'b11, p_paddr, p_pwrite, p_pwdata}) viol++;
`endif
            end
            if (p_pen && p_pready && bus.PENABLE) viol++;
            if (!p_acc && ({bus.PADDR, bus.PWRITE, bus.PWDATA} != {p_paddr, p_pwrite, p_pwdata})) viol++;
        end
        p_ok     = (rstn === 1'b1);
        p_psel   = bus.PSEL;
        p_pen    = bus.PENABLE;
        p_pwrite = bus.PWRITE;
        p_pready = bus.PREADY;
        p_paddr  = bus.PADDR;
        p_pwdata = bus.PWDATA;
        p_acc    = bus.REQ_VALID && bus.REQ_READY;
    end

    typedef struct {
        logic       vld, wr;
        logic [7:0] addr, wdata;
        logic       pready;
        logic       e_rdy, e_psel, e_pen, e_pwr;
        logic [7:0] e_paddr, e_pwdata;
        logic       e_rv;
        logic [7:0] e_rdata;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(logic vld, logic wr, logic [7:0] addr, logic [7:0] wdata, logic pready,
                                logic rdy, logic psel, logic pen, logic pwr, logic [7:0] pa,
                                logic [7:0] pd, logic rv, logic [7:0] rd, logic er);
        vec_t v;
        v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata; v.pready = pready;
        v.e_rdy = rdy; v.e_psel = psel; v.e_pen = pen; v.e_pwr = pwr;
        v.e_paddr = pa; v.e_pwdata = pd; v.e_rv = rv; v.e_rdata = rd; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic psel, input logic pen,
                           input logic pwr, input logic [7:0] pa, input logic [7:0] pd,
                           input logic rv, input logic [7:0] rd, input logic er);
        chk({tag, ".req_ready"}, bus.REQ_READY, rdy);
        chk({tag, ".psel"},      bus.PSEL,      psel);
        chk({tag, ".penable"},   bus.PENABLE,   pen);
        chk({tag, ".pwrite"},    bus.PWRITE,    pwr);
        chk({tag, ".paddr"},     bus.PADDR,     pa);
        chk({tag, ".pwdata"},    bus.PWDATA,    pd);
        chk({tag, ".rsp_valid"}, bus.RSP_VALID, rv);
        chk({tag, ".rsp_rdata"}, bus.RSP_RDATA, rd);
        chk({tag, ".rsp_err"},   bus.RSP_ERR,   er);
    endtask

    task automatic drive(input logic v, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic r);
        bus.REQ_VALID = v;
        bus.REQ_WRITE = w;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
        bus.PREADY    = r;
    endtask

    vec_t       vt [19];
    int         rv_seen;
    logic [7:0] last_rdata;

    initial begin
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        mem_clr = 1'b0;
        chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Write 0x5A to 0x12, then read it back; junk commands during SETUP/ACCESS are ignored.
        vt[0] = mk(1, 1, 8'h12, 8'h5A, 1,  0, 1, 0, 1, 8'h12, 8'h5A, 0, 8'h00, 0);
        vt[1] = mk(1, 0, 8'hFF, 8'hEE, 1,  0, 1, 1, 1, 8'h12, 8'h5A, 0, 8'h00, 0);
        vt[2] = mk(1, 0, 8'hFF, 8'hEE, 1,  1, 0, 0, 1, 8'h12, 8'h5A, 1, 8'h00, 0);
        vt[3] = mk(1, 0, 8'h12, 8'h33, 1,  0, 1, 0, 0, 8'h12, 8'h33, 0, 8'h00, 0);
        vt[4] = mk(0, 0, 8'h00, 8'h00, 1,  0, 1, 1, 0, 8'h12, 8'h33, 0, 8'h00, 0);
        vt[5] = mk(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 0, 8'h12, 8'h33, 1, 8'h5A, 0);
        vt[6] = mk(0, 0, 8'h00, 8'h00, 1,  1, 0, 0, 0, 8'h12, 8'h33, 0, 8'h5A, 0);
        // Four back-to-back writes to 0x00..0x03 with REQ_VALID held: one accept every 3 cycles.
        for (int j = 0; j < 12; j++) begin
            int c, p;
            c = j / 3;
            p = j % 3;
            if (p == 0)
                vt[7+j] = mk(1, 1, 8'(c), 8'(8'hA0 + c), 1,
                             0, 1, 0, 1, 8'(c), 8'(8'hA0 + c), 0, 8'h5A, 0);
            else
                vt[7+j] = mk(c < 3, 1, 8'(c + 1), 8'(8'hA1 + c), 1,
                             p == 2, p != 2, p == 1, 1, 8'(c), 8'(8'hA0 + c), p == 2, 8'h5A, 0);
        end

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].vld, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].pready);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_psel, vt[i].e_pen, vt[i].e_pwr,
                    vt[i].e_paddr, vt[i].e_pwdata, vt[i].e_rv, vt[i].e_rdata, vt[i].e_err);
        end

        // Read 0x02 with three wait states.
        drive(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("ws_setup", 0, 1, 0, 0, 8'h02, 8'h00, 0, 8'h5A, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("ws_access0", 0, 1, 1, 0, 8'h02, 8'h00, 0, 8'h5A, 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk_out($sformatf("ws_wait%0d", k), 0, 1, 1, 0, 8'h02, 8'h00, 0, 8'h5A, 0);
        end
        bus.PREADY = 1'b1;
        @(negedge clk);
        chk_out("ws_done", 1, 0, 0, 0, 8'h02, 8'h00, 1, 8'hA2, 0);
        @(negedge clk);
        chk("ws_pulse_end", bus.RSP_VALID, 1'b0);

        // Read 0x01 with PREADY stuck low.
        drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("stk_setup", 0, 1, 0, 0, 8'h01, 8'h00, 0, 8'hA2, 0);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("stk_access0", 0, 1, 1, 0, 8'h01, 8'h00, 0, 8'hA2, 0);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), {bus.PSEL, bus.PENABLE, bus.RSP_VALID}, 3'b110);
        end
        @(negedge clk);
        chk_out("to_abort", 1, 0, 0, 0, 8'h01, 8'h00, 1, 8'hA2, 1);
        @(negedge clk);
        chk("to_pulse_end", bus.RSP_VALID, 1'b0);
        drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        chk_out("to_next", 1, 0, 0, 0, 8'h03, 8'h00, 1, 8'hA3, 0);
        last_rdata = 8'hA3;
`else
        rv_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.RSP_VALID !== 1'b0) rv_seen++;
        end
        chk("stk_no_rsp", rv_seen, 0);
        chk("stk_still_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        bus.PREADY = 1'b1;
        @(negedge clk);
        chk_out("stk_late_done", 1, 0, 0, 0, 8'h01, 8'h00, 1, 8'hA1, 0);
        last_rdata = 8'hA1;
`endif

        // Reset for one edge during ACCESS of a write to 0x07.
        drive(1'b1, 1'b1, 8'h07, 8'h77, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("rst_access", 0, 1, 1, 1, 8'h07, 8'h77, 0, last_rdata, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_out("rst_after", 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0);
        bus.PREADY = 1'b1;
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.RSP_VALID !== 1'b0) rv_seen++;
        end
        chk("rst_no_rsp", rv_seen, 0);
        chk("rst_no_write", mem[7], 8'h00);

        // Normal read after the reset.
        drive(1'b1, 1'b0, 8'h03, 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        chk_out("post_rst_read", 1, 0, 0, 0, 8'h03, 8'h00, 1, 8'hA3, 0);

        chk("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
